// File: rtl/mcpwm_pkg.sv
// rtl/mcpwm_pkg.sv - shared constants and types for the multi-channel PWM
// Contents: counter mode selectors, counting-direction enum, channel limit.
package mcpwm_pkg;

  localparam int MODE_EDGE    = 0;
  localparam int MODE_CENTER  = 1;
  localparam int MAX_CHANNELS = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

endpackage

// File: rtl/mcpwm_if.sv
// rtl/mcpwm_if.sv - peripheral-bus bundle between software side and mcpwm
// Signals:
//   data_in       write data for period/duty loads
//   period_load   strobe, period shadow <= data_in
//   duty_load     per-channel strobes, duty shadow[i] <= data_in
//   counter_value live counter
//   period        active period
//   duty          duty shadows, channel 0 in LSBs
//   rollover      one-cycle pulse per PWM cycle
//   pwm_signal    registered PWM outputs
// Modports: master (software side), slave (mcpwm).
interface mcpwm_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);

  logic [WIDTH-1:0]          data_in;
  logic                      period_load;
  logic [CHANNELS-1:0]       duty_load;
  logic [WIDTH-1:0]          counter_value;
  logic [WIDTH-1:0]          period;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic                      rollover;
  logic [CHANNELS-1:0]       pwm_signal;

  modport master (
    output data_in, period_load, duty_load,
    input  counter_value, period, duty, rollover, pwm_signal
  );

  modport slave (
    input  data_in, period_load, duty_load,
    output counter_value, period, duty, rollover, pwm_signal
  );

endinterface

// File: rtl/mcpwm_channel.sv
// rtl/mcpwm_channel.sv - one PWM compare channel with double-buffered duty
// Ports:
//   sysclk, sysreset  clock, synchronous active-high reset
//   data_in           duty write data
//   duty_load         strobe, duty_shadow <= data_in
//   apply             rollover, duty_active <= duty_shadow
//   cnt               shared counter value
//   duty_shadow       shadow readback
//   pwm               registered compare output (cnt < duty_active)
module mcpwm_channel #(
  parameter int WIDTH = 16
) (
  input  logic             sysclk,
  input  logic             sysreset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             duty_load,
  input  logic             apply,
  input  logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] duty_shadow,
  output logic             pwm
);

  logic [WIDTH-1:0] duty_active;

  // apply samples the shadow before a same-edge load lands, so a write
  // coincident with rollover waits for the following rollover.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      duty_shadow <= '0;
      duty_active <= '0;
      pwm         <= 1'b0;
    end else begin
      if (duty_load) begin
        duty_shadow <= data_in;
      end
      if (apply) begin
        duty_active <= duty_shadow;
      end
      pwm <= (cnt < duty_active);
    end
  end

endmodule

// File: rtl/mcpwm.sv
// rtl/mcpwm.sv - multi-channel PWM with shared counter and shadowed period/duty
// Ports:
//   sysclk, sysreset  clock, synchronous active-high reset
//   counter_event     counter advances once per rising edge
//   bus               mcpwm_if slave: loads in, counter/period/duty/rollover/pwm out
// Parameters: WIDTH, CHANNELS (1..8), START (reset period), CENTER (0 edge, 1 up/down).
module mcpwm
  import mcpwm_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int START    = 65535,
  parameter int CENTER   = 0
) (
  input  logic   sysclk,
  input  logic   sysreset,
  input  logic   counter_event,
  mcpwm_if.slave bus
);

  localparam logic [WIDTH-1:0] START_V   = WIDTH'(START);
  localparam logic [WIDTH-1:0] ZERO      = '0;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam bit               IS_CENTER = (CENTER == MODE_CENTER);

  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("mcpwm: CHANNELS must be 1..8");
  end
  if (CENTER != MODE_EDGE && CENTER != MODE_CENTER) begin : g_bad_mode
    $error("mcpwm: CENTER must be 0 or 1");
  end

  logic             event_last;
  logic             event_edge;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period_shadow;
  logic [WIDTH-1:0] period_active;
  dir_t             dir;
  logic             roll;
  logic             rollover_q;
  logic [WIDTH-1:0] duty_arr [CHANNELS];
  logic             pwm_arr  [CHANNELS];

  assign event_edge = counter_event & ~event_last;

  // The cycle ends when the counter leaves 0; in center mode only on the
  // downward leg (dir never goes up while cnt is 0 during the up leg).
  always_comb begin
    roll = 1'b0;
    if (event_edge && cnt == ZERO) begin
      roll = IS_CENTER ? (dir == DIR_DOWN) : 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      event_last    <= 1'b0;
      cnt           <= IS_CENTER ? ZERO : START_V;
      dir           <= DIR_DOWN;
      period_shadow <= START_V;
      period_active <= START_V;
      rollover_q    <= 1'b0;
    end else begin
      event_last <= counter_event;
      rollover_q <= roll;
      if (bus.period_load) begin
        period_shadow <= bus.data_in;
      end
      if (roll) begin
        period_active <= period_shadow;
      end
      if (event_edge) begin
        if (!IS_CENTER) begin
          // Reload takes the shadow directly: it becomes the active period on this edge.
          cnt <= (cnt == ZERO) ? period_shadow : cnt - ONE;
        end else if (dir == DIR_UP) begin
          if (cnt == period_active) begin
            cnt <= cnt - ONE;
            dir <= DIR_DOWN;
          end else begin
            cnt <= cnt + ONE;
          end
        end else if (cnt == ZERO) begin
          // New period 0 parks the counter at 0, rolling over on every edge.
          if (period_shadow == ZERO) begin
            cnt <= ZERO;
            dir <= DIR_DOWN;
          end else begin
            cnt <= ONE;
            dir <= DIR_UP;
          end
        end else begin
          cnt <= cnt - ONE;
        end
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    mcpwm_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .sysclk      (sysclk),
      .sysreset    (sysreset),
      .data_in     (bus.data_in),
      .duty_load   (bus.duty_load[i]),
      .apply       (roll),
      .cnt         (cnt),
      .duty_shadow (duty_arr[i]),
      .pwm         (pwm_arr[i])
    );
  end

  assign bus.counter_value = cnt;
  assign bus.period        = period_active;
  assign bus.rollover      = rollover_q;

  always_comb begin
    bus.duty       = '0;
    bus.pwm_signal = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.duty[i*WIDTH +: WIDTH] = duty_arr[i];
      bus.pwm_signal[i]          = pwm_arr[i];
    end
  end

endmodule

// File: tb/tb_mcpwm.sv
// tb/tb_mcpwm.sv - directed self-checking bench for mcpwm (edge and center instances)
module tb_mcpwm;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic sysreset;
  logic ce_a;
  logic ce_b;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] sweep_vals [4] = '{8'd0, 8'd3, 8'd10, 8'd255};
  int         center_seq [6] = '{1, 2, 3, 2, 1, 0};

  mcpwm_if #(.WIDTH(8), .CHANNELS(4)) bus_a ();
  mcpwm_if #(.WIDTH(8), .CHANNELS(4)) bus_b ();

  mcpwm #(.WIDTH(8), .CHANNELS(4), .START(9), .CENTER(0)) u_edge (
    .sysclk        (sysclk),
    .sysreset      (sysreset),
    .counter_event (ce_a),
    .bus           (bus_a.slave)
  );

  mcpwm #(.WIDTH(8), .CHANNELS(4), .START(3), .CENTER(1)) u_center (
    .sysclk        (sysclk),
    .sysreset      (sysreset),
    .counter_event (ce_b),
    .bus           (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic edge_a();
    ce_a = 1'b1;
    step();
    ce_a = 1'b0;
  endtask

  task automatic edge_b();
    ce_b = 1'b1;
    step();
    ce_b = 1'b0;
  endtask

  // Ten edges starting with a rollover edge; counts ch1 high samples and rollovers.
  // mode 1: rewrite ch1 with 3/7 alternating every clock (ends on 7).
  // mode 2: write ch1 = 5 on the rollover clock only.
  task automatic cycle_a(input int mode, output int hi, output int rolls);
    hi    = 0;
    rolls = 0;
    for (int k = 0; k < 20; k++) begin
      bus_a.duty_load = 4'b0000;
      if (mode == 1) begin
        bus_a.data_in   = (k % 2 == 1) ? 8'd7 : 8'd3;
        bus_a.duty_load = 4'b0010;
      end else if (mode == 2 && k == 0) begin
        bus_a.data_in   = 8'd5;
        bus_a.duty_load = 4'b0010;
      end
      ce_a = (k % 2 == 0);
      step();
      bus_a.duty_load = 4'b0000;
      if (k % 2 == 0 && bus_a.rollover) rolls++;
      if (k % 2 == 1 && bus_a.pwm_signal[1]) hi++;
    end
    ce_a = 1'b0;
  endtask

  initial begin
    int         rolls;
    int         hi;
    logic [3:0] pwm_or;
    logic [3:0] ep;
    int         c;

    sysreset = 1'b1;
    ce_a = 1'b0;
    ce_b = 1'b0;
    bus_a.data_in = '0; bus_a.period_load = 1'b0; bus_a.duty_load = '0;
    bus_b.data_in = '0; bus_b.period_load = 1'b0; bus_b.duty_load = '0;
    step();
    step();
    sysreset = 1'b0;

    check("rst_cnt", 32'(bus_a.counter_value), 32'd9);
    check("rst_period", 32'(bus_a.period), 32'd9);
    check("rst_duty", bus_a.duty, 32'h0);
    check("rst_rollover", 32'(bus_a.rollover), 32'd0);
    check("rst_pwm", 32'(bus_a.pwm_signal), 32'd0);
    check("rst_center_cnt", 32'(bus_b.counter_value), 32'd0);

    // 10 edges from reset: 8..0 then reload to 9
    rolls  = 0;
    pwm_or = '0;
    for (int k = 0; k < 10; k++) begin
      edge_a();
      check($sformatf("dflt_cnt%0d", k), 32'(bus_a.counter_value), (k == 9) ? 32'd9 : 32'(8 - k));
      if (bus_a.rollover) rolls++;
      pwm_or |= bus_a.pwm_signal;
      step();
      if (bus_a.rollover) rolls++;
      pwm_or |= bus_a.pwm_signal;
    end
    check("dflt_rolls", 32'(rolls), 32'd1);
    check("dflt_pwm_low", 32'(pwm_or), 32'd0);

    // Duty sweep loaded mid-cycle (cnt 8)
    edge_a();
    step();
    for (int ch = 0; ch < 4; ch++) begin
      bus_a.data_in   = sweep_vals[ch];
      bus_a.duty_load = 4'(1 << ch);
      step();
    end
    bus_a.duty_load = '0;
    check("sweep_readback", bus_a.duty, 32'hFF0A0300);
    pwm_or = bus_a.pwm_signal;
    for (int k = 0; k < 8; k++) begin
      edge_a();
      step();
      pwm_or |= bus_a.pwm_signal;
    end
    check("sweep_hold_pwm", 32'(pwm_or), 32'd0);
    check("sweep_cnt0", 32'(bus_a.counter_value), 32'd0);
    for (int e = 0; e < 10; e++) begin
      edge_a();
      if (e == 0) check("sweep_roll", 32'(bus_a.rollover), 32'd1);
      step();
      c  = 9 - e;
      ep = 4'b1100 | ((c < 3) ? 4'b0010 : 4'b0000);
      check($sformatf("sweep_pwm_c%0d", c), 32'(bus_a.pwm_signal), 32'(ep));
    end

    // Glitch-free duty update on ch1
    cycle_a(1, hi, rolls);
    check("glitch_a_width", 32'(hi), 32'd3);
    check("glitch_a_rolls", 32'(rolls), 32'd1);
    check("glitch_a_shadow", 32'(bus_a.duty[15:8]), 32'd7);
    cycle_a(2, hi, rolls);
    check("glitch_b_width", 32'(hi), 32'd7);
    check("glitch_b_shadow", 32'(bus_a.duty[15:8]), 32'd5);
    cycle_a(0, hi, rolls);
    check("glitch_c_width", 32'(hi), 32'd5);
    check("glitch_c_rolls", 32'(rolls), 32'd1);

    // Period change 9 -> 4 loaded at cnt 6
    for (int k = 0; k < 4; k++) begin
      edge_a();
      step();
    end
    check("per_cnt6", 32'(bus_a.counter_value), 32'd6);
    bus_a.data_in     = 8'd4;
    bus_a.period_load = 1'b1;
    step();
    bus_a.period_load = 1'b0;
    check("per_hold", 32'(bus_a.period), 32'd9);
    for (int k = 0; k < 6; k++) begin
      edge_a();
      check($sformatf("per_old_cnt%0d", 5 - k), 32'(bus_a.counter_value), 32'(5 - k));
      check($sformatf("per_old_noroll%0d", k), 32'(bus_a.rollover), 32'd0);
      step();
    end
    check("per_hold_at0", 32'(bus_a.period), 32'd9);
    edge_a();
    check("per_reload_cnt", 32'(bus_a.counter_value), 32'd4);
    check("per_reload_roll", 32'(bus_a.rollover), 32'd1);
    step();
    check("per_active", 32'(bus_a.period), 32'd4);
    for (int k = 0; k < 4; k++) begin
      edge_a();
      check($sformatf("per_new_cnt%0d", 3 - k), 32'(bus_a.counter_value), 32'(3 - k));
      step();
    end
    edge_a();
    check("per_new_roll", 32'(bus_a.rollover), 32'd1);
    check("per_new_reload", 32'(bus_a.counter_value), 32'd4);
    step();

    // Level held high advances only once
    ce_a = 1'b1;
    for (int k = 0; k < 5; k++) step();
    ce_a = 1'b0;
    step();
    check("level_once", 32'(bus_a.counter_value), 32'd3);
    check("pre_reset_pwm", 32'(bus_a.pwm_signal), 32'hE);

    // Reset wins over duty_load and event in the same cycle
    bus_a.data_in   = 8'h55;
    bus_a.duty_load = 4'hF;
    ce_a            = 1'b1;
    sysreset        = 1'b1;
    step();
    sysreset        = 1'b0;
    bus_a.duty_load = '0;
    ce_a            = 1'b0;
    check("mrst_cnt", 32'(bus_a.counter_value), 32'd9);
    check("mrst_period", 32'(bus_a.period), 32'd9);
    check("mrst_duty", bus_a.duty, 32'h0);
    check("mrst_rollover", 32'(bus_a.rollover), 32'd0);
    check("mrst_pwm", 32'(bus_a.pwm_signal), 32'd0);
    for (int k = 0; k < 10; k++) begin
      edge_a();
      step();
    end
    check("mrst_reload_start", 32'(bus_a.counter_value), 32'd9);
    check("mrst_pwm_after_roll", 32'(bus_a.pwm_signal), 32'd0);

    // Center-aligned: P=3, duty 2 on ch0
    check("ctr_rst_cnt", 32'(bus_b.counter_value), 32'd0);
    bus_b.data_in   = 8'd2;
    bus_b.duty_load = 4'b0001;
    step();
    bus_b.duty_load = '0;
    for (int k = 0; k < 12; k++) begin
      edge_b();
      c = center_seq[k % 6];
      check($sformatf("ctr_cnt_e%0d", k), 32'(bus_b.counter_value), 32'(c));
      check($sformatf("ctr_roll_e%0d", k), 32'(bus_b.rollover), (k % 6 == 0) ? 32'd1 : 32'd0);
      check($sformatf("ctr_pwm_lag_e%0d", k), 32'(bus_b.pwm_signal[0]),
            (k == 0) ? 32'd0 : ((center_seq[(k + 5) % 6] < 2) ? 32'd1 : 32'd0));
      step();
      check($sformatf("ctr_pwm_e%0d", k), 32'(bus_b.pwm_signal[0]), (c < 2) ? 32'd1 : 32'd0);
    end

    // Center-aligned with period 0 parks at 0
    bus_b.data_in     = 8'd0;
    bus_b.period_load = 1'b1;
    step();
    bus_b.period_load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      edge_b();
      check($sformatf("ctr_p0_cnt%0d", k), 32'(bus_b.counter_value), 32'd0);
      check($sformatf("ctr_p0_roll%0d", k), 32'(bus_b.rollover), 32'd1);
      step();
      check($sformatf("ctr_p0_period%0d", k), 32'(bus_b.period), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
